// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
// Imported by the round-robin arbiter and the top-level arbiter.
package sp_ram_arb_pkg;

    typedef enum logic {INIT, ARB} arb_state_e;

    // Port-id width; never below one bit so a single-bit id is always legal.
    function automatic int unsigned port_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// and moves the pointer just past the winner when the grant is taken.
module sp_ram_rr_arb
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic                                 advance_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    output logic [port_id_w(NUM_PORTS)-1:0]      id_o
);

    localparam int unsigned ID_W = port_id_w(NUM_PORTS);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin : l_pick
        logic        found;
        int unsigned idx;
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_PORTS;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (id_o == ID_W'(NUM_PORTS - 1)) ? '0 : id_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between NUM_PORTS
// requesters with round-robin arbitration and an optional post-reset zero-fill.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic                                          clk,
    input  logic                                          rst_i,
    input  logic [NUM_PORTS-1:0]                          req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]          addr_i,
    input  logic [NUM_PORTS-1:0]                          we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]        be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]          wdata_i,
    output logic [NUM_PORTS-1:0]                          gnt_o,
    output logic [NUM_PORTS-1:0]                          rvalid_o,
    output logic [DATA_WIDTH-1:0]                         rdata_o,
    output logic                                          init_done_o,
    output logic                                          ram_en_o,
    output logic [ADDR_WIDTH-1:0]                         ram_addr_o,
    output logic                                          ram_we_o,
    output logic [DATA_WIDTH/8-1:0]                       ram_be_o,
    output logic [DATA_WIDTH-1:0]                         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                         ram_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_W    = $clog2(BE_WIDTH);
    localparam int unsigned CNT_W    = ADDR_WIDTH - OFF_W;
    localparam int unsigned WORDS    = RAM_SIZE / BE_WIDTH;
    localparam int unsigned ID_W     = port_id_w(NUM_PORTS);
    localparam arb_state_e  RST_STATE = INIT_ZERO ? INIT : ARB;

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  init_last;
    logic [NUM_PORTS-1:0]  arb_gnt;
    logic [ID_W-1:0]       arb_id;
    logic                  advance;
    logic                  rsp_valid_q;
    logic [ID_W-1:0]       rsp_id_q;

    sp_ram_rr_arb #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arb (
        .clk       (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (advance),
        .gnt_o     (arb_gnt),
        .id_o      (arb_id)
    );

    assign init_last = (cnt_q == CNT_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_last) begin
            state_d = ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Everything RAM-facing is forced to zero while reset is held.
    always_comb begin
        gnt_o       = '0;
        advance     = 1'b0;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                INIT: begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_be_o   = '1;
                    ram_addr_o = {cnt_q, {OFF_W{1'b0}}};
                end
                ARB: begin
                    if (|req_i) begin
                        gnt_o       = arb_gnt;
                        advance     = 1'b1;
                        ram_en_o    = 1'b1;
                        ram_addr_o  = addr_i[arb_id];
                        ram_we_o    = we_i[arb_id];
                        ram_be_o    = be_i[arb_id];
                        ram_wdata_o = wdata_i[arb_id];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= |gnt_o;
            rsp_id_q    <= arb_id;
        end
    end

    // A pending response is dropped if reset arrives in its cycle.
    always_comb begin
        rvalid_o = '0;
        if (rsp_valid_q && !rst_i) begin
            rvalid_o[rsp_id_q] = 1'b1;
        end
    end

    assign rdata_o     = ram_rdata_i;
    assign init_done_o = INIT_ZERO ? ((state_q == ARB) && !rst_i) : 1'b1;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: a behavioural arbitration/memory model
// predicts grants and responses; a monitor checks responses as they appear.
module tb_sp_ram_arbiter;

    localparam int NP = 2;
    localparam int AW = 6;
    localparam int DW = 32;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [NP-1:0]            req_i;
    logic [NP-1:0][AW-1:0]    addr_i;
    logic [NP-1:0]            we_i;
    logic [NP-1:0][3:0]       be_i;
    logic [NP-1:0][DW-1:0]    wdata_i;
    logic [NP-1:0]            gnt_o;
    logic [NP-1:0]            rvalid_o;
    logic [DW-1:0]            rdata_o;
    logic                     init_done_o;
    logic                     ram_en_o;
    logic [AW-1:0]            ram_addr_o;
    logic                     ram_we_o;
    logic [3:0]               ram_be_o;
    logic [DW-1:0]            ram_wdata_o;
    logic [DW-1:0]            ram_rdata_i;

    sp_ram_arbiter #(
        .NUM_PORTS  (NP),
        .RAM_SIZE   (64),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_ZERO  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .init_done_o (init_done_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM wrapper model: garbage contents until written, 1-cycle read latency.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        ram_rdata_i = '0;
    end
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_addr_o[5:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= mem[ram_addr_o[5:2]];
            end
        end
    end

    // Reference model: byte array that is all zero once zero-fill has run.
    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [64];
    int          ref_ptr = 0;
    bit          mon_en = 1'b0;
    logic [NP-1:0] model_gnt = '0;

    initial for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;

    always @(negedge clk) begin
        int   w;
        int   a;
        exp_t e;
        model_gnt = '0;
        if (rst_i) begin
            ref_ptr = 0;
        end else if (mon_en) begin
            w = -1;
            for (int i = 0; i < NP; i++)
                if (w < 0 && req_i[(ref_ptr + i) % NP]) w = (ref_ptr + i) % NP;
            if (w >= 0) begin
                chk("gnt", gnt_o, 64'(1) << w);
                chk("ram_en", ram_en_o, 1);
                chk("ram_addr", ram_addr_o, addr_i[w]);
                chk("ram_we", ram_we_o, we_i[w]);
                a = int'(addr_i[w]);
                e.port = w;
                e.rd   = !we_i[w];
                e.data = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
                e.due  = cyc + 1;
                q.push_back(e);
                if (we_i[w])
                    for (int b = 0; b < 4; b++)
                        if (be_i[w][b]) ref_mem[a+b] = wdata_i[w][8*b +: 8];
                ref_ptr = (w + 1) % NP;
                model_gnt[w] = 1'b1;
            end else begin
                chk("gnt_idle", gnt_o, 0);
                chk("ram_en_idle", ram_en_o, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rvalid", rvalid_o, 64'(1) << e.port);
                if (e.rd) chk("rdata", rdata_o, e.data);
            end else begin
                chk("rvalid_idle", rvalid_o, 0);
            end
        end
    end

    task automatic set_port(input int p, input bit we, input int a, input logic [3:0] be,
                            input logic [31:0] d);
        req_i[p]   = 1'b1;
        we_i[p]    = we;
        addr_i[p]  = AW'(a);
        be_i[p]    = be;
        wdata_i[p] = d;
    endtask

    task automatic tick(input logic [NP-1:0] eg, input bit do_chk);
        @(negedge clk);
        if (do_chk) chk("dir_gnt", gnt_o, eg);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (model_gnt[p]) req_i[p] = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_ram_en", ram_en_o, 0);
        chk("rst_ram_we", ram_we_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_ram_be", ram_be_o, 0);
        chk("rst_ram_wdata", ram_wdata_o, 0);
    endtask

    task automatic init_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("init_en", ram_en_o, 1);
            chk("init_we", ram_we_o, 1);
            chk("init_be", ram_be_o, 4'hF);
            chk("init_wdata", ram_wdata_o, 0);
            chk("init_addr", ram_addr_o, 64'(k * 4));
            chk("init_gnt", gnt_o, 0);
            chk("init_done_low", init_done_o, 0);
            chk("init_rvalid", rvalid_o, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i   = 1'b1;
        req_i   = '0;
        addr_i  = '0;
        we_i    = '0;
        be_i    = '0;
        wdata_i = '0;
        // Requests held through reset and zero-fill must never be granted.
        set_port(0, 1'b1, 'h08, 4'hF, 32'h1111_1111);
        set_port(1, 1'b0, 'h0C, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        init_check(16);
        req_i = '0;
        @(negedge clk);
        chk("init_done_high", init_done_o, 1);
        chk("post_init_gnt", gnt_o, 0);
        chk("post_init_en", ram_en_o, 0);
        @(posedge clk);
        #1;

        mon_en = 1'b1;
        set_port(0, 1'b0, 'h20, 4'hF, 32'h0);
        tick(2'b01, 1'b1);
        set_port(0, 1'b1, 'h10, 4'b0011, 32'hDEAD_BEEF);
        tick(2'b01, 1'b1);
        set_port(1, 1'b0, 'h10, 4'hF, 32'h0);
        tick(2'b10, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1'b0, 'h10, 4'hF, 32'h0);
            set_port(1, 1'b0, 'h04, 4'hF, 32'h0);
            tick((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
        end
        req_i = '0;
        for (int i = 0; i < 3; i++) begin
            set_port(1, 1'b0, 'h18, 4'hF, 32'h0);
            tick(2'b10, 1'b1);
        end
        set_port(0, 1'b0, 'h1C, 4'hF, 32'h0);
        set_port(1, 1'b0, 'h18, 4'hF, 32'h0);
        tick(2'b01, 1'b1);

        repeat (400) begin
            for (int p = 0; p < NP; p++) begin
                if (req_i[p] && $urandom_range(7) == 0) req_i[p] = 1'b0;
                if (!req_i[p] && $urandom_range(1) == 1)
                    set_port(p, 1'($urandom_range(1)), int'($urandom_range(15)) * 4,
                             4'($urandom), $urandom);
            end
            tick('0, 1'b0);
        end
        req_i = '0;
        repeat (3) tick('0, 1'b0);
        chk("queue_drained", q.size(), 0);
        mon_en = 1'b0;

        // Reset in the middle of zero-fill restarts the fill from address 0.
        req_i = 2'b11;
        rst_i = 1'b1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        init_check(5);
        rst_i = 1'b1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        init_check(16);
        req_i = '0;
        @(negedge clk);
        chk("init_done_high2", init_done_o, 1);
        @(posedge clk);
        #1;

        // Reset in the cycle after a grant suppresses its response.
        set_port(0, 1'b0, 'h20, 4'hF, 32'h0);
        @(negedge clk);
        chk("pre_rst_gnt", gnt_o, 2'b01);
        @(posedge clk);
        #1;
        req_i = '0;
        rst_i = 1'b1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", rvalid_o, 0);
        chk("post_rst_init_done", init_done_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
